// File: rtl/quad_enc_pkg.sv
// Shared types and constants for the quadrature encoder bank.
// Optional glitch filter is enabled with the QUAD_ENC_FILTER_EN macro.
package quad_enc_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } ch_state_e;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Pipeline depth of the input synchroniser.
  localparam int PRIME_CYCLES = 2;

  // Classify the move from the previous {a,b} pair to the current one.
  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else begin
      case ({prev, cur})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
        default:                            s = STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One quadrature channel: synchroniser, optional glitch filter
// (QUAD_ENC_FILTER_EN), PRIME/RUN FSM, step decode, counter and sticky fault.
//
// state | meaning
// PRIME | after reset; prev follows the decoded pair, no decode, no faults
// RUN   | decode prev -> current every cycle
module quad_enc_channel
  import quad_enc_pkg::*;
#(
  parameter int COUNT_W    = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_a,
  input  logic               i_b,
  input  logic               i_count_clear,
  input  logic               i_fault_clear,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_faultn,
  output logic               o_dir
);

`ifdef QUAD_ENC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // PRIME must outlast the synchroniser (and filter) so that prev already
  // holds the resting pin state when decoding starts.
  localparam int PRIME_LEN = PRIME_CYCLES + (FILTER_EN ? FILTER_LEN : 0);

  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         w_cur;
  logic [1:0]         r_prev;
  logic [4:0]         r_prime_cnt;
  logic               w_prime_done;
  ch_state_e          r_state;
  ch_state_e          w_state_nxt;
  step_e              w_step;
  logic [COUNT_W-1:0] r_count;
  logic               r_faultn;
  logic               r_dir;

  // Two-stage synchroniser for the asynchronous {a,b} pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_a, i_b};
      r_sync2 <= r_sync1;
    end
  end

`ifdef QUAD_ENC_FILTER_EN
  logic [1:0] r_filt;
  logic [3:0] r_fcnt [2];

  // Each bit follows its synchronised input only after FILTER_LEN
  // consecutive samples disagree with the current filtered value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt    <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == 4'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_cur = r_filt;
`else
  assign w_cur = r_sync2;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= PRIME;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: leave PRIME once the prime counter expires.
  always_comb begin
    w_state_nxt  = r_state;
    w_prime_done = (r_prime_cnt == 5'(PRIME_LEN));
    case (r_state)
      PRIME:   if (w_prime_done) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = PRIME;
    endcase
  end

  // Prime cycle counter, frozen once complete.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                 r_prime_cnt <= '0;
    else if (r_state == PRIME && !w_prime_done) r_prime_cnt <= r_prime_cnt + 5'd1;
  end

  assign w_step = (r_state == RUN) ? decode_step(r_prev, w_cur) : STEP_NONE;

  // Position counter, direction and sticky fault; clear has lower priority
  // than a fault but higher priority than a step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev   <= '0;
      r_count  <= '0;
      r_faultn <= 1'b1;
      r_dir    <= 1'b0;
    end else begin
      r_prev <= w_cur;
      if (i_count_clear)             r_count <= '0;
      else if (w_step == STEP_FWD)   r_count <= r_count + COUNT_W'(1);
      else if (w_step == STEP_REV)   r_count <= r_count - COUNT_W'(1);
      if (w_step == STEP_FWD)        r_dir <= 1'b1;
      else if (w_step == STEP_REV)   r_dir <= 1'b0;
      if (w_step == STEP_ILLEGAL)    r_faultn <= 1'b0;
      else if (i_fault_clear)        r_faultn <= 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_faultn = r_faultn;
  assign o_dir    = r_dir;

endmodule

// File: rtl/quad_enc_bank.sv
// Multi-channel quadrature decoder bank with coherent snapshot handshake.
// Optional glitch filter in every channel is enabled with QUAD_ENC_FILTER_EN.
module quad_enc_bank #(
  parameter int NUM_CH     = 2,
  parameter int COUNT_W    = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enc_a,
  input  logic [NUM_CH-1:0]           enc_b,
  input  logic [NUM_CH-1:0]           count_clear,
  input  logic [NUM_CH-1:0]           fault_clear,
  input  logic                        snap_req,
  output logic                        snap_ack,
  output logic [NUM_CH*COUNT_W-1:0]   snap_count,
  output logic [NUM_CH*COUNT_W-1:0]   count,
  output logic [NUM_CH-1:0]           faultn,
  output logic [NUM_CH-1:0]           dir
);

  logic [NUM_CH*COUNT_W-1:0] w_count;
  logic [NUM_CH*COUNT_W-1:0] r_snap_count;
  logic                      r_req_q1;
  logic                      r_req_q2;
  logic                      r_snap_ack;
  logic                      w_snap_edge;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_enc_channel #(
      .COUNT_W    (COUNT_W),
      .FILTER_LEN (FILTER_LEN)
    ) u_ch (
      .i_clk         (CLK),
      .i_rst         (reset),
      .i_a           (enc_a[i]),
      .i_b           (enc_b[i]),
      .i_count_clear (count_clear[i]),
      .i_fault_clear (fault_clear[i]),
      .o_count       (w_count[i*COUNT_W +: COUNT_W]),
      .o_faultn      (faultn[i]),
      .o_dir         (dir[i])
    );
  end

  assign w_snap_edge = r_req_q1 & ~r_req_q2;

  // Register the request, detect its rising edge and capture every
  // channel's count from the same cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_req_q1     <= 1'b0;
      r_req_q2     <= 1'b0;
      r_snap_ack   <= 1'b0;
      r_snap_count <= '0;
    end else begin
      r_req_q1   <= snap_req;
      r_req_q2   <= r_req_q1;
      r_snap_ack <= w_snap_edge;
      if (w_snap_edge) r_snap_count <= w_count;
    end
  end

  assign count      = w_count;
  assign snap_count = r_snap_count;
  assign snap_ack   = r_snap_ack;

endmodule

// File: tb/tb_quad_enc_bank.sv
// Self-checking bench for quad_enc_bank: a 2-channel 32-bit instance and a
// 1-channel 8-bit instance for wrap-around.
module tb_quad_enc_bank;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  enc_a, enc_b, count_clear, fault_clear;
  logic        snap_req;
  logic        snap_ack;
  logic [63:0] snap_count, count;
  logic [1:0]  faultn, dir;

  logic        enc_a2, enc_b2, count_clear2, fault_clear2, snap_req2;
  logic        snap_ack2, faultn2, dir2;
  logic [7:0]  snap_count2, count2;

  always #5 CLK = ~CLK;

  quad_enc_bank #(.NUM_CH(2), .COUNT_W(32), .FILTER_LEN(3)) dut (
    .CLK(CLK), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .count_clear(count_clear), .fault_clear(fault_clear),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_count(snap_count),
    .count(count), .faultn(faultn), .dir(dir)
  );

  quad_enc_bank #(.NUM_CH(1), .COUNT_W(8), .FILTER_LEN(3)) dut8 (
    .CLK(CLK), .reset(reset), .enc_a(enc_a2), .enc_b(enc_b2),
    .count_clear(count_clear2), .fault_clear(fault_clear2),
    .snap_req(snap_req2), .snap_ack(snap_ack2), .snap_count(snap_count2),
    .count(count2), .faultn(faultn2), .dir(dir2)
  );

  typedef struct {
    string       name;
    int          sel;
    int          ch;
    logic [63:0] exp;
  } exp_t;

  typedef struct {
    logic [1:0]  p0;
    logic [1:0]  p1;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [1:0]  dr;
    logic [1:0]  fn;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m0, m1;
  logic [1:0] p2;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] probe(input int sel, input int ch);
    case (sel)
      0: return {32'd0, count[ch*32 +: 32]};
      1: return {63'd0, dir[ch]};
      2: return {63'd0, faultn[ch]};
      3: return {63'd0, snap_ack};
      4: return {32'd0, snap_count[ch*32 +: 32]};
      5: return {56'd0, count2};
      6: return {63'd0, dir2};
      7: return {63'd0, faultn2};
      default: return {55'd0, snap_ack2, snap_count2};
    endcase
  endfunction

  task automatic expect_val(input string nm, input int sel, input int ch, input logic [63:0] e);
    exp_t r;
    r.name = nm; r.sel = sel; r.ch = ch; r.exp = e;
    sb.push_back(r);
  endtask

  task automatic check_sb();
    exp_t r;
    logic [63:0] act;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      act = probe(r.sel, r.ch);
      n_cmp++;
      if (act !== r.exp) begin
        n_err++;
        $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", r.name, r.ch, act, r.exp, $time);
      end
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] p);
    case (p)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] p);
    case (p)
      2'b00: return 2'b10;
      2'b10: return 2'b11;
      2'b11: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_counts(input string nm, input int a, input int b);
    logic [31:0] ea, eb;
    ea = a; eb = b;
    expect_val(nm, 0, 0, {32'd0, ea});
    expect_val(nm, 0, 1, {32'd0, eb});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [13];
    vt[0]  = '{2'b01, 2'b00, 32'd1, 32'd0,         2'b01, 2'b11};
    vt[1]  = '{2'b11, 2'b00, 32'd2, 32'd0,         2'b01, 2'b11};
    vt[2]  = '{2'b10, 2'b00, 32'd3, 32'd0,         2'b01, 2'b11};
    vt[3]  = '{2'b00, 2'b00, 32'd4, 32'd0,         2'b01, 2'b11};
    vt[4]  = '{2'b00, 2'b10, 32'd4, 32'hFFFFFFFF,  2'b01, 2'b11};
    vt[5]  = '{2'b00, 2'b11, 32'd4, 32'hFFFFFFFE,  2'b01, 2'b11};
    vt[6]  = '{2'b00, 2'b01, 32'd4, 32'hFFFFFFFD,  2'b01, 2'b11};
    vt[7]  = '{2'b00, 2'b00, 32'd4, 32'hFFFFFFFC,  2'b01, 2'b11};
    vt[8]  = '{2'b00, 2'b10, 32'd4, 32'hFFFFFFFB,  2'b01, 2'b11};
    vt[9]  = '{2'b00, 2'b11, 32'd4, 32'hFFFFFFFA,  2'b01, 2'b11};
    vt[10] = '{2'b00, 2'b01, 32'd4, 32'hFFFFFFF9,  2'b01, 2'b11};
    vt[11] = '{2'b00, 2'b00, 32'd4, 32'hFFFFFFF8,  2'b01, 2'b11};
    vt[12] = '{2'b11, 2'b00, 32'd4, 32'hFFFFFFF8,  2'b01, 2'b10};

    reset = 1'b1; enc_a = '0; enc_b = '0; count_clear = '0; fault_clear = '0; snap_req = 1'b0;
    enc_a2 = 1'b0; enc_b2 = 1'b0; count_clear2 = 1'b0; fault_clear2 = 1'b0; snap_req2 = 1'b0;
    tick(3);
    push_counts("rst_count", 0, 0);
    for (int c = 0; c < 2; c++) begin
      expect_val("rst_faultn", 2, c, 64'd1);
      expect_val("rst_dir", 1, c, 64'd0);
      expect_val("rst_snap_count", 4, c, 64'd0);
    end
    expect_val("rst_snap_ack", 3, 0, 64'd0);
    expect_val("rst_count8", 5, 0, 64'd0);
    expect_val("rst_faultn8", 7, 0, 64'd1);
    expect_val("rst_snap8", 8, 0, 64'd0);
    check_sb();
    reset = 1'b0;
    tick(5);

    // Forward on ch0, reverse on ch1, then an illegal jump on ch0.
    for (int i = 0; i < 13; i++) begin
      enc_a = {vt[i].p1[1], vt[i].p0[1]};
      enc_b = {vt[i].p1[0], vt[i].p0[0]};
      tick(4);
      expect_val($sformatf("vec%0d_count", i), 0, 0, {32'd0, vt[i].c0});
      expect_val($sformatf("vec%0d_count", i), 0, 1, {32'd0, vt[i].c1});
      for (int c = 0; c < 2; c++) begin
        expect_val($sformatf("vec%0d_dir", i), 1, c, {63'd0, vt[i].dr[c]});
        expect_val($sformatf("vec%0d_faultn", i), 2, c, {63'd0, vt[i].fn[c]});
      end
      check_sb();
    end

    // fault_clear pulse releases the sticky fault.
    fault_clear = 2'b01; tick(1); fault_clear = 2'b00; tick(1);
    expect_val("fclr_faultn", 2, 0, 64'd1);
    check_sb();

    // fault_clear coincident with a second illegal jump: fault wins.
    enc_a = 2'b00; enc_b = 2'b00;
    tick(2);
    fault_clear = 2'b01; tick(1); fault_clear = 2'b00;
    expect_val("fclr_vs_illegal_faultn", 2, 0, 64'd0);
    expect_val("fclr_vs_illegal_count", 0, 0, 64'd4);
    check_sb();
    tick(1);
    fault_clear = 2'b01; tick(1); fault_clear = 2'b00; tick(1);
    expect_val("fclr2_faultn", 2, 0, 64'd1);
    check_sb();

    // Coherent snapshot while both channels step forward.
    m0 = 4; m1 = -8;
    fork
      begin : stepper
        logic [1:0] pp;
        pp = 2'b00;
        for (int s = 0; s < 10; s++) begin
          pp = fwd(pp);
          enc_a = {pp[1], pp[1]};
          enc_b = {pp[0], pp[0]};
          tick(3);
          m0 = m0 + 1; m1 = m1 + 1;
          tick(1);
        end
      end
      begin : snapper
        int e0, e1;
        logic [31:0] s0, s1;
        tick(9); #2;
        snap_req = 1'b1;
        tick(1); #2;
        e0 = m0; e1 = m1;
        expect_val("snap_ack_early", 3, 0, 64'd0);
        check_sb();
        tick(1);
        s0 = e0; s1 = e1;
        expect_val("snap_ack_pulse", 3, 0, 64'd1);
        expect_val("snap_count", 4, 0, {32'd0, s0});
        expect_val("snap_count", 4, 1, {32'd0, s1});
        check_sb();
        for (int h = 0; h < 6; h++) begin
          tick(1);
          expect_val("snap_ack_held", 3, 0, 64'd0);
          check_sb();
        end
        snap_req = 1'b0;
      end
    join
    push_counts("after_stepping_count", 14, 2);
    expect_val("after_stepping_faultn", 2, 0, 64'd1);
    expect_val("after_stepping_faultn", 2, 1, 64'd1);
    check_sb();

    // Reset mid-run with a snapshot ack pending; pins rest at 11.
    snap_req = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
    expect_val("midrst_snap_ack", 3, 0, 64'd0);
    push_counts("midrst_count", 0, 0);
    for (int c = 0; c < 2; c++) begin
      expect_val("midrst_snap_count", 4, c, 64'd0);
      expect_val("midrst_dir", 1, c, 64'd0);
      expect_val("midrst_faultn", 2, c, 64'd1);
    end
    check_sb();
    reset = 1'b0; snap_req = 1'b0;
    tick(8);
    push_counts("post_rst_count", 0, 0);
    expect_val("post_rst_faultn", 2, 0, 64'd1);
    expect_val("post_rst_faultn", 2, 1, 64'd1);
    check_sb();
    enc_a = 2'b11; enc_b = 2'b10;
    tick(4);
    push_counts("post_rst_step_count", 1, 0);
    expect_val("post_rst_step_dir", 1, 0, 64'd1);
    expect_val("post_rst_step_faultn", 2, 0, 64'd1);
    check_sb();

    // 8-bit wrap-around on the second instance.
    p2 = 2'b00;
    for (int s = 0; s < 127; s++) begin
      p2 = fwd(p2); enc_a2 = p2[1]; enc_b2 = p2[0];
      tick(4);
    end
    expect_val("wrap_preset_127", 5, 0, 64'h7F);
    check_sb();
    p2 = fwd(p2); enc_a2 = p2[1]; enc_b2 = p2[0]; tick(4);
    expect_val("wrap_max_plus_1", 5, 0, 64'h80);
    expect_val("wrap_dir_fwd", 6, 0, 64'd1);
    check_sb();
    p2 = rev(p2); enc_a2 = p2[1]; enc_b2 = p2[0]; tick(4);
    expect_val("wrap_min_minus_1", 5, 0, 64'h7F);
    expect_val("wrap_dir_rev", 6, 0, 64'd0);
    check_sb();
    p2 = fwd(p2); enc_a2 = p2[1]; enc_b2 = p2[0]; tick(4);
    expect_val("wrap_again", 5, 0, 64'h80);
    check_sb();

    // count_clear coincident with a step: clear wins.
    p2 = fwd(p2); enc_a2 = p2[1]; enc_b2 = p2[0];
    tick(2);
    count_clear2 = 1'b1; tick(1); count_clear2 = 1'b0;
    expect_val("clear_vs_step", 5, 0, 64'd0);
    check_sb();
    tick(3);
    expect_val("clear_vs_step_hold", 5, 0, 64'd0);
    expect_val("clear_faultn8", 7, 0, 64'd1);
    check_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
